// File: rtl/dest_reg_pipe_if.sv
// Decode-side bundle for dest_reg_pipe: destination-select inputs, hazard sources,
// and the per-stage destination / forwarding / hazard results.
interface dest_reg_pipe_if #(
    parameter int ADDR_W = 5,
    parameter int STAGES = 3,
    parameter int FW     = $clog2(STAGES + 1)
);
    logic [ADDR_W-1:0]        rt_i;
    logic [ADDR_W-1:0]        rd_i;
    logic [1:0]               reg_dst_i;
    logic                     reg_write_i;
    logic                     mem_read_i;
    logic                     valid_i;
    logic                     stall_i;
    logic                     flush_i;
    logic [ADDR_W-1:0]        rs_src_i;
    logic [ADDR_W-1:0]        rt_src_i;
    logic [ADDR_W-1:0]        wr_o;
    logic [STAGES*ADDR_W-1:0] stage_wr_o;
    logic [STAGES-1:0]        stage_we_o;
    logic [STAGES-1:0]        stage_ld_o;
    logic [FW-1:0]            fwd_a_o;
    logic [FW-1:0]            fwd_b_o;
    logic                     load_use_o;
    logic [ADDR_W-1:0]        wb_wr_o;
    logic                     wb_we_o;

    modport master (
        output rt_i, rd_i, reg_dst_i, reg_write_i, mem_read_i, valid_i,
               stall_i, flush_i, rs_src_i, rt_src_i,
        input  wr_o, stage_wr_o, stage_we_o, stage_ld_o, fwd_a_o, fwd_b_o,
               load_use_o, wb_wr_o, wb_we_o
    );

    modport slave (
        input  rt_i, rd_i, reg_dst_i, reg_write_i, mem_read_i, valid_i,
               stall_i, flush_i, rs_src_i, rt_src_i,
        output wr_o, stage_wr_o, stage_we_o, stage_ld_o, fwd_a_o, fwd_b_o,
               load_use_o, wb_wr_o, wb_we_o
    );
endinterface

// File: rtl/dest_reg_pipe.sv
// Destination-register select plus a STAGES-deep destination/write-enable pipe,
// with youngest-wins forwarding selects and a stage-1 load-use hazard flag.
module dest_reg_pipe #(
    parameter int ADDR_W   = 5,
    parameter int STAGES   = 3,
    parameter int LINK_REG = 31,
    parameter int FW       = $clog2(STAGES + 1)
) (
    input logic            clk,
    input logic            rst_n,
    dest_reg_pipe_if.slave bus
);
    localparam logic [ADDR_W-1:0] LINK = ADDR_W'(LINK_REG);

    logic [ADDR_W-1:0] wr_sel;
    logic              en1;
    logic [ADDR_W-1:0] wr_p [STAGES];
    logic [STAGES-1:0] we_p;
    logic [STAGES-1:0] ld_p;
    logic [STAGES-1:0] hit_a;
    logic [STAGES-1:0] hit_b;
    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;

    // ---- decode: destination select ----
    always_comb begin
        case (bus.reg_dst_i)
            2'b00:   wr_sel = bus.rt_i;
            2'b01:   wr_sel = bus.rd_i;
            2'b10:   wr_sel = LINK;
            default: wr_sel = '0;
        endcase
    end

    assign en1 = bus.valid_i & bus.reg_write_i & (bus.reg_dst_i != 2'b11) & (wr_sel != '0);

    // ---- stage 1 capture, stages 2..STAGES free-running shift ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                wr_p[k] <= '0;
            end
            we_p <= '0;
            ld_p <= '0;
        end else begin
            if (bus.flush_i || bus.stall_i) begin
                wr_p[0] <= '0;
                we_p[0] <= 1'b0;
                ld_p[0] <= 1'b0;
            end else begin
                wr_p[0] <= wr_sel;
                we_p[0] <= en1;
                ld_p[0] <= bus.mem_read_i & en1;
            end
            for (int k = 1; k < STAGES; k++) begin
                wr_p[k] <= wr_p[k-1];
                we_p[k] <= we_p[k-1];
                ld_p[k] <= ld_p[k-1];
            end
        end
    end

    // ---- forwarding / hazard from stage registers ----
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        fwd_a = '0;
        fwd_b = '0;
        for (int k = 0; k < STAGES; k++) begin
            hit_a[k] = we_p[k] && (wr_p[k] == bus.rs_src_i) && (bus.rs_src_i != '0);
            hit_b[k] = we_p[k] && (wr_p[k] == bus.rt_src_i) && (bus.rt_src_i != '0);
        end
        // Walk oldest to youngest so the youngest match is the one that sticks.
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (hit_a[k]) fwd_a = FW'(k + 1);
            if (hit_b[k]) fwd_b = FW'(k + 1);
        end
    end

    always_comb begin
        bus.stage_wr_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            bus.stage_wr_o[k*ADDR_W +: ADDR_W] = wr_p[k];
        end
    end

    assign bus.wr_o       = wr_sel;
    assign bus.stage_we_o = we_p;
    assign bus.stage_ld_o = ld_p;
    assign bus.fwd_a_o    = fwd_a;
    assign bus.fwd_b_o    = fwd_b;
    assign bus.load_use_o = ld_p[0] & (hit_a[0] | hit_b[0]);
    assign bus.wb_wr_o    = wr_p[STAGES-1];
    assign bus.wb_we_o    = we_p[STAGES-1];
endmodule
